int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/irq_sync.sv | 44 ++++
 rtl/int_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_int_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the interrupt controller slice:
//                interrupt line count, CP0 Status bit positions, controller
//                FSM state encoding, the "no source" service id and the
//                priority encoder helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Number of external interrupt lines (hardware interrupts IP7..IP2).
  localparam int NUM_IRQ = 6;

  // CP0 Status bit positions.
  localparam int IE    = 0;   // global interrupt enable
  localparam int EXL   = 1;   // exception level, blocks interrupts when set
  localparam int IM_LO = 10;  // interrupt mask, lowest bit
  localparam int IM_HI = 15;  // interrupt mask, highest bit

  // Service id reported when no source is being serviced (or spurious ack).
  localparam logic [2:0] SRV_NONE = 3'd7;

  // Controller FSM state encoding.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } ic_state_e;

  // Index of the highest set bit of vec; SRV_NONE when vec is all zeros.
  // The loop runs upward so the last (highest) set bit wins.
  function automatic logic [2:0] prio_enc(input logic [NUM_IRQ-1:0] vec);
    logic [2:0] id;
    id = SRV_NONE;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (vec[i]) begin
        id = 3'(i);
      end
    end
    return id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync
//  Description : Single interrupt line front end. Two-flop synchronizer for
//                the asynchronous input, followed by a history flop used for
//                rising-edge detection.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                i_irq   - asynchronous interrupt line
//                o_level - synchronized line level (second sync stage)
//                o_edge  - one-cycle rising-edge strobe (sync2 & ~history)
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_irq,
  output logic o_level,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  // History clears with the synchronizer, so a line that is already high
  // when reset is released produces exactly one edge afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_irq;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_level = r_sync2;
  assign o_edge  = r_sync2 & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : CP0-side interrupt controller. Synchronizes six external
//                interrupt lines, keeps a pending vector (edge or level per
//                line), masks it with Status.IM, and hands the highest
//                priority source to the CPU through a REQ/SERVICE handshake.
//  Parameters  : EDGE_MASK - per-line trigger mode, 1 = rising edge,
//                            0 = level (high)
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                irq_in    - asynchronous interrupt lines, bit 5 highest
//                status    - CP0 Status (IE bit 0, EXL bit 1, IM 15:10)
//                inta      - CPU accepts the interrupt this cycle
//                excp_ret  - CPU executes an exception return
//                intr      - registered interrupt request to CPU/CP0
//                int_level - registered masked pending vector (Cause.IP)
//                srv_id    - index of serviced source, 7 = none/spurious
//                srv_valid - high while a source is being serviced
//  Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
  import mips_pkg::*;
#(
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = 6'b111111
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        status,
  input  logic               inta,
  input  logic               excp_ret,
  output logic               intr,
  output logic [NUM_IRQ-1:0] int_level,
  output logic [2:0]         srv_id,
  output logic               srv_valid
);

  // --------------------------------------------------------------------------
  // Line front ends
  // --------------------------------------------------------------------------
  logic [NUM_IRQ-1:0] w_sync_lvl;
  logic [NUM_IRQ-1:0] w_edge;

  generate
    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
      irq_sync u_irq_sync (
        .clk     (clk),
        .rst     (rst),
        .i_irq   (irq_in[g]),
        .o_level (w_sync_lvl[g]),
        .o_edge  (w_edge[g])
      );
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Pending vector, masking and request qualification
  // --------------------------------------------------------------------------
  ic_state_e          r_state;
  ic_state_e          w_state_nxt;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_pending_nxt;
  logic [NUM_IRQ-1:0] w_masked;
  logic               w_req_ok;
  logic               w_take;
  logic [2:0]         w_srv_nxt;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] r_int_level;
  logic [2:0]         r_srv_id;
  logic               w_intr;
  logic               w_srv_valid;

  // Status bits outside IE/EXL/IM play no part in interrupt delivery.
  logic w_unused_status;
  assign w_unused_status = ^{status[31:IM_HI+1], status[IM_LO-1:EXL+1]};

  assign w_masked = r_pending & status[IM_HI:IM_LO];
  assign w_req_ok = status[IE] & ~status[EXL] & (|w_masked);

  // The CPU acknowledge only counts while a request is outstanding.
  assign w_take    = (r_state == S_REQ) & inta;
  assign w_srv_nxt = prio_enc(w_masked);

  // Acknowledge clears the captured source, edge lines only. A spurious
  // acknowledge (w_srv_nxt == SRV_NONE) matches no line and clears nothing.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = w_take & (w_srv_nxt == 3'(i));
    end
    w_clr = w_clr & EDGE_MASK;
  end

  // Edge lines latch until cleared; a new edge in the clear cycle is OR-ed
  // in after the clear so it is not lost. Level lines simply follow sync2.
  assign w_pending_nxt = ( EDGE_MASK & ((r_pending & ~w_clr) | w_edge)) |
                         (~EDGE_MASK & w_sync_lvl);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= '0;
      r_int_level <= '0;
    end else begin
      r_pending   <= w_pending_nxt;
      r_int_level <= w_masked;
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Controller FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_ok) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // Acknowledge has priority over withdrawal: once the CPU has taken
        // the interrupt it must be serviced, even if nothing is left.
        if (inta) begin
          w_state_nxt = S_SERVICE;
        end else if (!w_req_ok) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SERVICE: begin
        if (excp_ret) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Controller FSM: outputs (pure decode of the state register)
  // --------------------------------------------------------------------------
  always_comb begin
    w_intr      = 1'b0;
    w_srv_valid = 1'b0;
    case (r_state)
      S_REQ:     w_intr      = 1'b1;
      S_SERVICE: w_srv_valid = 1'b1;
      default: begin
        w_intr      = 1'b0;
        w_srv_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Serviced source id: captured on acknowledge, released on return
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_srv_id <= SRV_NONE;
    end else if (w_take) begin
      r_srv_id <= w_srv_nxt;
    end else if ((r_state == S_SERVICE) && excp_ret) begin
      r_srv_id <= SRV_NONE;
    end
  end

  assign intr      = w_intr;
  assign srv_valid = w_srv_valid;
  assign int_level = r_int_level;
  assign srv_id    = r_srv_id;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Self-checking bench for int_ctrl. Stimulus pushes the hand
//                computed output set expected for the current cycle into a
//                queue; a monitor on the falling edge pops and compares.
//                Line 0 is built as a level line, lines 1..5 as edge lines.
//  Revision    : 1.1 - end-of-run completeness checks
// ============================================================================
module tb_int_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  irq_in;
    logic [31:0] status;
    logic        inta;
    logic        excp_ret;
    logic        intr;
    logic [5:0]  int_level;
    logic [2:0]  srv_id;
    logic        srv_valid;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic       intr;
        logic [5:0] lvl;
        logic [2:0] id;
        logic       vld;
    } exp_t;

    exp_t q[$];

    int_ctrl #(.EDGE_MASK(6'b111110)) dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .status    (status),
        .inta      (inta),
        .excp_ret  (excp_ret),
        .intr      (intr),
        .int_level (int_level),
        .srv_id    (srv_id),
        .srv_valid (srv_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if (e.cyc != cyc || intr !== e.intr || int_level !== e.lvl ||
                srv_id !== e.id || srv_valid !== e.vld) begin
                n_bad++;
                $display("FAIL %s cyc=%0d (due %0d): got intr=%b lvl=%b id=%0d vld=%b, want intr=%b lvl=%b id=%0d vld=%b",
                         e.name, cyc, e.cyc, intr, int_level, srv_id, srv_valid,
                         e.intr, e.lvl, e.id, e.vld);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic ei, input logic [5:0] el,
                       input logic [2:0] eid, input logic ev);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.intr = ei;
        e.lvl  = el;
        e.id   = eid;
        e.vld  = ev;
        q.push_back(e);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cyc=%0d want < 10000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1; irq_in = '0; status = '0; inta = 1'b0; excp_ret = 1'b0;
        tick(); tick(); tick();
        chk("rst_hold", 1'b0, 6'b000000, 3'd7, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst_rel", 1'b0, 6'b000000, 3'd7, 1'b0);

        status = 32'h0000FF01;
        inta = 1'b1;
        tick();
        chk("idle_inta_ign", 1'b0, 6'b000000, 3'd7, 1'b0);
        inta = 1'b0;
        irq_in = 6'b000100;
        tick();
        irq_in = '0;
        tick(); tick();
        chk("t1_pending", 1'b0, 6'b000000, 3'd7, 1'b0);
        tick();
        chk("t1_req", 1'b1, 6'b000100, 3'd7, 1'b0);
        inta = 1'b1;
        tick();
        chk("t1_ack", 1'b0, 6'b000100, 3'd2, 1'b1);
        inta = 1'b0;
        tick();
        chk("t1_cleared", 1'b0, 6'b000000, 3'd2, 1'b1);
        excp_ret = 1'b1;
        tick();
        chk("t1_ret", 1'b0, 6'b000000, 3'd7, 1'b0);
        excp_ret = 1'b0;

        irq_in = 6'b100010;
        tick();
        irq_in = '0;
        tick(); tick();
        chk("t2_pending", 1'b0, 6'b000000, 3'd7, 1'b0);
        tick();
        chk("t2_req", 1'b1, 6'b100010, 3'd7, 1'b0);
        inta = 1'b1;
        tick();
        chk("t2_ack5", 1'b0, 6'b100010, 3'd5, 1'b1);
        tick();
        chk("t2_svc_inta_ign", 1'b0, 6'b000010, 3'd5, 1'b1);
        inta = 1'b0;
        excp_ret = 1'b1;
        tick();
        chk("t2_ret", 1'b0, 6'b000010, 3'd7, 1'b0);
        excp_ret = 1'b0;
        tick();
        chk("t2_rereq", 1'b1, 6'b000010, 3'd7, 1'b0);
        excp_ret = 1'b1;
        tick();
        chk("t2_req_ret_ign", 1'b1, 6'b000010, 3'd7, 1'b0);
        excp_ret = 1'b0;
        inta = 1'b1;
        tick();
        chk("t2_ack1", 1'b0, 6'b000010, 3'd1, 1'b1);
        inta = 1'b0;
        tick();
        chk("t2_cleared", 1'b0, 6'b000000, 3'd1, 1'b1);
        excp_ret = 1'b1;
        tick();
        chk("t2_ret2", 1'b0, 6'b000000, 3'd7, 1'b0);
        excp_ret = 1'b0;

        status = 32'h00000401;
        irq_in = 6'b001000;
        tick();
        irq_in = '0;
        tick(); tick(); tick();
        chk("t3_masked", 1'b0, 6'b000000, 3'd7, 1'b0);
        status = 32'h00002001;
        tick();
        chk("t3_unmasked", 1'b1, 6'b001000, 3'd7, 1'b0);
        inta = 1'b1;
        tick();
        chk("t3_ack", 1'b0, 6'b001000, 3'd3, 1'b1);
        inta = 1'b0;
        excp_ret = 1'b1;
        tick();
        chk("t3_ret", 1'b0, 6'b000000, 3'd7, 1'b0);
        excp_ret = 1'b0;

        status = 32'h0000FF01;
        irq_in = 6'b000100;
        tick();
        irq_in = '0;
        tick();
        irq_in = 6'b000100;
        tick();
        irq_in = '0;
        chk("t4_pending", 1'b0, 6'b000000, 3'd7, 1'b0);
        tick();
        chk("t4_req", 1'b1, 6'b000100, 3'd7, 1'b0);
        inta = 1'b1;
        tick();
        chk("t4_ack", 1'b0, 6'b000100, 3'd2, 1'b1);
        inta = 1'b0;
        tick();
        chk("t4_set_wins", 1'b0, 6'b000100, 3'd2, 1'b1);
        excp_ret = 1'b1;
        tick();
        chk("t4_ret", 1'b0, 6'b000100, 3'd7, 1'b0);
        excp_ret = 1'b0;
        tick();
        chk("t4_rereq", 1'b1, 6'b000100, 3'd7, 1'b0);
        inta = 1'b1;
        tick();
        chk("t4_ack2", 1'b0, 6'b000100, 3'd2, 1'b1);
        inta = 1'b0;
        excp_ret = 1'b1;
        tick();
        chk("t4_ret2", 1'b0, 6'b000000, 3'd7, 1'b0);
        excp_ret = 1'b0;

        irq_in = 6'b001000;
        tick();
        irq_in = '0;
        tick(); tick(); tick();
        chk("t5_req", 1'b1, 6'b001000, 3'd7, 1'b0);
        status = 32'h00000001;
        inta = 1'b1;
        tick();
        chk("t5_spurious", 1'b0, 6'b000000, 3'd7, 1'b1);
        inta = 1'b0;
        excp_ret = 1'b1;
        tick();
        chk("t5_ret", 1'b0, 6'b000000, 3'd7, 1'b0);
        excp_ret = 1'b0;
        status = 32'h0000FF01;
        tick();
        chk("t5_not_cleared", 1'b1, 6'b001000, 3'd7, 1'b0);
        inta = 1'b1;
        tick();
        chk("t5_ack3", 1'b0, 6'b001000, 3'd3, 1'b1);
        inta = 1'b0;
        excp_ret = 1'b1;
        tick();
        chk("t5_ret2", 1'b0, 6'b000000, 3'd7, 1'b0);
        excp_ret = 1'b0;

        irq_in = 6'b000001;
        tick(); tick(); tick(); tick();
        chk("t6_req", 1'b1, 6'b000001, 3'd7, 1'b0);
        irq_in = '0;
        tick();
        chk("t6_hold1", 1'b1, 6'b000001, 3'd7, 1'b0);
        tick();
        chk("t6_hold2", 1'b1, 6'b000001, 3'd7, 1'b0);
        tick();
        chk("t6_pend_low", 1'b1, 6'b000001, 3'd7, 1'b0);
        tick();
        chk("t6_withdrawn", 1'b0, 6'b000000, 3'd7, 1'b0);

        status = 32'h0000FF03;
        irq_in = 6'b010000;
        tick();
        irq_in = '0;
        tick(); tick(); tick();
        chk("t7_exl1", 1'b0, 6'b010000, 3'd7, 1'b0);
        tick();
        chk("t7_exl2", 1'b0, 6'b010000, 3'd7, 1'b0);
        status = 32'h0000FF01;
        tick();
        chk("t7_exl_clear", 1'b1, 6'b010000, 3'd7, 1'b0);
        rst = 1'b1;
        tick();
        chk("t8_rst_req", 1'b0, 6'b000000, 3'd7, 1'b0);
        rst = 1'b0;
        tick();
        chk("t8_after1", 1'b0, 6'b000000, 3'd7, 1'b0);
        tick();
        chk("t8_after2", 1'b0, 6'b000000, 3'd7, 1'b0);

        tick(); tick();
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d expectations left, want 0", q.size());
        end
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL coverage: got %0d comparisons, want >= 12", n_cmp);
        end
        if (n_bad != 0) begin
            $display("FAIL overall: got %0d mismatches, want 0", n_bad);
        end else begin
            $display("PASS all %0d comparisons", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
